// File: rtl/mskand_bitserial_pkg.sv
// Shared types and helpers for the bit-serial masked AND sequencer.
//   state_t : sequencer FSM states
//   idx     : flat index of share s of bit k in a k*D+s sharing layout
//   ridx    : randomness bit used by the share pair (i,j), i<j, in a d-share DOM gadget
package mskand_bitserial_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  function automatic int idx(input int k, input int s, input int d);
    return k * d + s;
  endfunction

  // Pairs are enumerated row-wise: (0,1),(0,2)..(0,d-1),(1,2)...
  function automatic int ridx(input int i, input int j, input int d);
    return i * d - (i * (i + 1)) / 2 + (j - i - 1);
  endfunction

endpackage

// File: rtl/MSKand_dom.sv
// d-share domain-oriented-masking AND gadget, one register stage.
//   clk, rst : clock, async active-high reset
//   ina, inb : one bit's d shares of each operand
//   rnd      : d*(d-1)/2 fresh random bits, one per share pair
//   out      : d shares of ina&inb, valid the cycle after the inputs
// Every cross-domain product is blinded with its pair's random bit before
// the register, so the output XOR tree never sees an unblinded cross term.
module MSKand_dom
  import mskand_bitserial_pkg::*;
#(
  parameter int d = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [d-1:0]           ina,
  input  logic [d-1:0]           inb,
  input  logic [d*(d-1)/2-1:0]   rnd,
  output logic [d-1:0]           out
);

  logic [d-1:0][d-1:0] term_d, term_q;

  always_comb begin
    term_d = '0;
    for (int i = 0; i < d; i++) begin
      for (int j = 0; j < d; j++) begin
        if (i == j)
          term_d[i][j] = ina[i] & inb[j];
        else if (i < j)
          term_d[i][j] = (ina[i] & inb[j]) ^ rnd[ridx(i, j, d)];
        else
          term_d[i][j] = (ina[i] & inb[j]) ^ rnd[ridx(j, i, d)];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) term_q <= '0;
    else     term_q <= term_d;
  end

  // Integration stays inside share domain i: only row i terms are combined.
  always_comb begin
    out = '0;
    for (int i = 0; i < d; i++)
      for (int j = 0; j < d; j++)
        out[i] = out[i] ^ term_q[i][j];
  end

endmodule

// File: rtl/mskand_bitserial_seq.sv
// Bit-serial masked AND: computes a W-bit shared a&b through one DOM gadget,
// one bit per cycle in which the PRNG supplies a fresh word.
//   clk, rst            : clock, async active-high reset
//   in_valid/in_ready   : operand handshake (ready only in IDLE)
//   in_a, in_b          : operand sharings, bit k share s at k*D+s
//   rnd_valid/rnd_ready : PRNG handshake, ready only on an issue cycle
//   rnd                 : N_RND fresh random bits
//   out_valid/out_ready : result handshake, out held stable in DONE
//   out                 : result sharing, same layout as in_a
//   busy                : high outside IDLE
module mskand_bitserial_seq
  import mskand_bitserial_pkg::*;
#(
  parameter int D = 2,
  parameter int W = 8,
  localparam int N_RND = D * (D - 1) / 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [W*D-1:0]     in_a,
  input  logic [W*D-1:0]     in_b,
  input  logic               rnd_valid,
  output logic               rnd_ready,
  input  logic [N_RND-1:0]   rnd,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [W*D-1:0]     out,
  output logic               busy
);

  localparam int CW = (W > 1) ? $clog2(W) : 1;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, idx_q;
  logic              issue, issue_q;
  logic [W*D-1:0]    a_q, b_q, res_q;
  logic [D-1:0]      g_a, g_b, g_out;
  logic [N_RND-1:0]  g_r;

  always_comb begin
    state_d = state_q;
    issue   = 1'b0;
    case (state_q)
      IDLE:  if (in_valid) state_d = RUN;
      RUN: begin
        issue = rnd_valid;
        if (issue && cnt_q == CW'(W - 1)) state_d = DRAIN;
      end
      DRAIN: state_d = DONE;
      DONE:  if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign out_valid = (state_q == DONE);
  assign rnd_ready = issue;
  assign out       = res_q;

  // Gadget inputs are forced to zero unless a fresh rnd word is consumed
  // this cycle, so no operand share ever meets stale or missing randomness.
  assign g_a = issue ? a_q[idx(int'(cnt_q), 0, D) +: D] : '0;
  assign g_b = issue ? b_q[idx(int'(cnt_q), 0, D) +: D] : '0;
  assign g_r = issue ? rnd : '0;

  MSKand_dom #(.d(D)) u_dom (
    .clk (clk),
    .rst (rst),
    .ina (g_a),
    .inb (g_b),
    .rnd (g_r),
    .out (g_out)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      issue_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      issue_q <= issue;
      if (state_q == IDLE && in_valid) begin
        a_q   <= in_a;
        b_q   <= in_b;
        cnt_q <= '0;
      end
      if (issue) begin
        idx_q <= cnt_q;
        cnt_q <= cnt_q + CW'(1);
      end
      // Gadget output for the bit issued last cycle is ready now.
      if (issue_q) res_q[idx(int'(idx_q), 0, D) +: D] <= g_out;
    end
  end

endmodule

// File: tb/tb_mskand_bitserial_seq.sv
// Directed bench: a D=2/W=4 instance for the sequencing scenarios and a
// D=3/W=8 instance for randomness-consumption checks.
module tb_mskand_bitserial_seq;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // D=2, W=4 instance
  logic       in_valid, in_ready, rnd_valid, rnd_ready, out_valid, out_ready, busy;
  logic [7:0] in_a, in_b, out;
  logic [0:0] rnd;

  // D=3, W=8 instance
  logic        in_valid3, in_ready3, rnd_valid3, rnd_ready3, out_valid3, out_ready3, busy3;
  logic [23:0] in_a3, in_b3, out3;
  logic [2:0]  rnd3;

  int n_vec = 0;
  int n_err = 0;
  logic [2:0] q3[$];

  mskand_bitserial_seq #(.D(2), .W(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .rnd_valid(rnd_valid), .rnd_ready(rnd_ready), .rnd(rnd),
    .out_valid(out_valid), .out_ready(out_ready), .out(out), .busy(busy)
  );

  mskand_bitserial_seq #(.D(3), .W(8)) dut3 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid3), .in_ready(in_ready3), .in_a(in_a3), .in_b(in_b3),
    .rnd_valid(rnd_valid3), .rnd_ready(rnd_ready3), .rnd(rnd3),
    .out_valid(out_valid3), .out_ready(out_ready3), .out(out3), .busy(busy3)
  );

  function automatic logic [7:0] share2(input logic [3:0] v);
    logic [7:0] s;
    logic r;
    for (int k = 0; k < 4; k++) begin
      r = 1'($urandom_range(0, 1));
      s[2*k]   = r;
      s[2*k+1] = v[k] ^ r;
    end
    return s;
  endfunction

  function automatic logic [3:0] recomb2(input logic [7:0] s);
    logic [3:0] v;
    for (int k = 0; k < 4; k++) v[k] = s[2*k] ^ s[2*k+1];
    return v;
  endfunction

  function automatic logic [23:0] share3(input logic [7:0] v);
    logic [23:0] s;
    logic r0, r1;
    for (int k = 0; k < 8; k++) begin
      r0 = 1'($urandom_range(0, 1));
      r1 = 1'($urandom_range(0, 1));
      s[3*k]   = r0;
      s[3*k+1] = r1;
      s[3*k+2] = v[k] ^ r0 ^ r1;
    end
    return s;
  endfunction

  function automatic logic [7:0] recomb3(input logic [23:0] s);
    logic [7:0] v;
    for (int k = 0; k < 8; k++) v[k] = s[3*k] ^ s[3*k+1] ^ s[3*k+2];
    return v;
  endfunction

  // Called at a negedge; offers the operands, then runs until out_valid
  // (bounded). pat gives rnd_valid for the first plen RUN cycles, 1 after.
  // Returns edges after accept, rnd handshakes, and non-issue cycles where
  // the gadget saw anything nonzero.
  task automatic run_op(input logic [7:0] sa, input logic [7:0] sb,
                        input logic [15:0] pat, input int plen,
                        output int edges, output int hs, output int viol);
    int p;
    in_valid = 1'b1; in_a = sa; in_b = sb; out_ready = 1'b0;
    rnd_valid = 1'b1; rnd = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    edges = 0; hs = 0; viol = 0; p = 0;
    while (!out_valid && edges < 64) begin
      rnd_valid = (p < plen) ? pat[p] : 1'b1;
      p++;
      rnd = rnd_valid ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      if (rnd_valid && rnd_ready) hs++;
      if (!rnd_ready && (dut.u_dom.ina != 0 || dut.u_dom.inb != 0 || dut.u_dom.rnd != 0))
        viol++;
      @(negedge clk);
      edges++;
    end
  endtask

  task automatic finish_op();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  // D=3 driver: rnd_valid alternates 1,0,1,0..., stall cycles offer 3'b111.
  task automatic run3(input logic [23:0] sa, input logic [23:0] sb, input logic [2:0] word,
                      output int edges, output int bad);
    int p;
    in_valid3 = 1'b1; in_a3 = sa; in_b3 = sb; out_ready3 = 1'b0;
    rnd_valid3 = 1'b0; rnd3 = 3'b111;
    @(negedge clk);
    in_valid3 = 1'b0;
    edges = 0; bad = 0; p = 0;
    q3.delete();
    while (!out_valid3 && edges < 64) begin
      rnd_valid3 = (p % 2 == 0);
      p++;
      rnd3 = rnd_valid3 ? word : 3'b111;
      #1;
      if (rnd_valid3 && rnd_ready3) begin
        q3.push_back(rnd3);
        if (dut3.u_dom.rnd != rnd3) bad++;
      end else if (dut3.u_dom.rnd != 0 || dut3.u_dom.ina != 0 || dut3.u_dom.inb != 0) begin
        bad++;
      end
      @(negedge clk);
      edges++;
    end
    rnd_valid3 = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 0; in_a = '0; in_b = '0; rnd_valid = 1'b1; rnd = 1'b1; out_ready = 1'b1;
    in_valid3 = 0; in_a3 = '0; in_b3 = '0; rnd_valid3 = 0; rnd3 = '0; out_ready3 = 0;
    @(negedge clk); @(negedge clk);
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    n_vec++; if (out !== 8'h00) begin n_err++; $display("FAIL reset_out got %h want 00", out); end
    n_vec++; if (rnd_ready !== 1'b0) begin n_err++; $display("FAIL reset_rnd_ready got %b want 0", rnd_ready); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", busy); end
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    rst = 1'b0; out_ready = 1'b0; rnd_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int e, h, v;
    run_op(share2(4'b1011), share2(4'b0110), 16'h0, 0, e, h, v);
    n_vec++; if (recomb2(out) !== 4'b0010) begin n_err++; $display("FAIL basic_result got %b want 0010", recomb2(out)); end
    n_vec++; if (e !== 5) begin n_err++; $display("FAIL basic_latency got %0d want 5", e); end
    n_vec++; if (h !== 4) begin n_err++; $display("FAIL basic_handshakes got %0d want 4", h); end
    n_vec++; if (v !== 0) begin n_err++; $display("FAIL basic_gating got %0d want 0", v); end
    finish_op();
  endtask

  task automatic test_rnd_stall();
    int e, h, v;
    // RUN-cycle rnd_valid sequence 1,0,0,1,1,0,1 (bit 0 first)
    run_op(share2(4'b1011), share2(4'b0110), 16'h0059, 7, e, h, v);
    n_vec++; if (recomb2(out) !== 4'b0010) begin n_err++; $display("FAIL stall_result got %b want 0010", recomb2(out)); end
    n_vec++; if (e !== 8) begin n_err++; $display("FAIL stall_latency got %0d want 8", e); end
    n_vec++; if (h !== 4) begin n_err++; $display("FAIL stall_handshakes got %0d want 4", h); end
    n_vec++; if (v !== 0) begin n_err++; $display("FAIL stall_gating got %0d want 0", v); end
    finish_op();
  endtask

  task automatic test_backpressure();
    int e, h, v;
    logic [7:0] saved;
    run_op(share2(4'b1011), share2(4'b0110), 16'h0, 0, e, h, v);
    saved = out;
    for (int c = 0; c < 3; c++) begin
      in_valid = 1'b1; in_a = 8'hFF; in_b = 8'hFF; rnd_valid = 1'b1; out_ready = 1'b0;
      @(negedge clk); #1;
      n_vec++; if (out !== saved) begin n_err++; $display("FAIL bp_out_stable cyc %0d got %h want %h", c, out, saved); end
      n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL bp_out_valid cyc %0d got %b want 1", c, out_valid); end
      n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_in_ready cyc %0d got %b want 0", c, in_ready); end
      n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL bp_busy cyc %0d got %b want 1", c, busy); end
      n_vec++; if (rnd_ready !== 1'b0) begin n_err++; $display("FAIL bp_rnd_ready cyc %0d got %b want 0", c, rnd_ready); end
    end
    in_valid = 1'b0;
    finish_op(); #1;
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL bp_release_out_valid got %b want 0", out_valid); end
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL bp_release_in_ready got %b want 1", in_ready); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int e, h, v;
    in_valid = 1'b1; in_a = share2(4'b1011); in_b = share2(4'b0110); rnd_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk); @(negedge clk);
    rst = 1'b1; #1;
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rstmid_out_valid got %b want 0", out_valid); end
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rstmid_in_ready got %b want 1", in_ready); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rstmid_busy got %b want 0", busy); end
    n_vec++; if (out !== 8'h00) begin n_err++; $display("FAIL rstmid_out got %h want 00", out); end
    @(negedge clk);
    rst = 1'b0;
    run_op(share2(4'b1111), share2(4'b1111), 16'h0, 0, e, h, v);
    n_vec++; if (recomb2(out) !== 4'b1111) begin n_err++; $display("FAIL rstmid_next_result got %b want 1111", recomb2(out)); end
    n_vec++; if (e !== 5) begin n_err++; $display("FAIL rstmid_next_latency got %0d want 5", e); end
    finish_op();
  endtask

  task automatic test_back_to_back();
    int e, h, v;
    logic [7:0] sa, sb;
    run_op(share2(4'b1011), share2(4'b0110), 16'h0, 0, e, h, v);
    sa = share2(4'b0101); sb = share2(4'b0011);
    out_ready = 1'b1; in_valid = 1'b1; in_a = sa; in_b = sb; #1;
    n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL b2b_done_in_ready got %b want 0", in_ready); end
    @(negedge clk); #1;
    n_vec++; if (in_ready !== 1'b1 || busy !== 1'b0) begin n_err++; $display("FAIL b2b_idle got in_ready=%b busy=%b want 1/0", in_ready, busy); end
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL b2b_out_valid got %b want 0", out_valid); end
    run_op(sa, sb, 16'h0, 0, e, h, v);
    n_vec++; if (recomb2(out) !== 4'b0001) begin n_err++; $display("FAIL b2b_result got %b want 0001", recomb2(out)); end
    n_vec++; if (e !== 5) begin n_err++; $display("FAIL b2b_latency got %0d want 5", e); end
    finish_op();
  endtask

  task automatic test_fresh();
    int e, bad;
    logic [23:0] sa, sb, r1, r2;
    sa = share3(8'hE7); sb = share3(8'h3C);
    for (int run = 0; run < 2; run++) begin
      // Run 0 sets r01, run 1 sets r01 and r02: shares 0 and 2 must differ.
      run3(sa, sb, (run == 0) ? 3'b001 : 3'b011, e, bad);
      if (run == 0) r1 = out3; else r2 = out3;
      n_vec++; if (recomb3(out3) !== 8'h24) begin n_err++; $display("FAIL fresh_result run %0d got %h want 24", run, recomb3(out3)); end
      n_vec++; if (e !== 16) begin n_err++; $display("FAIL fresh_latency run %0d got %0d want 16", run, e); end
      n_vec++; if (bad !== 0) begin n_err++; $display("FAIL fresh_gadget_rnd run %0d got %0d bad cycles want 0", run, bad); end
      n_vec++; if (q3.size() !== 8) begin n_err++; $display("FAIL fresh_handshakes run %0d got %0d want 8", run, q3.size()); end
      for (int i = 0; i < q3.size(); i++) begin
        n_vec++;
        if (q3[i] !== ((run == 0) ? 3'b001 : 3'b011)) begin
          n_err++; $display("FAIL fresh_word run %0d idx %0d got %b", run, i, q3[i]);
        end
      end
      out_ready3 = 1'b1;
      @(negedge clk);
      out_ready3 = 1'b0;
    end
    n_vec++; if (r1 === r2) begin n_err++; $display("FAIL fresh_shares_vary got %h for both seeds want different", r1); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_rnd_stall();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    test_fresh();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
